bp_tile_cfg_sequencer: RTL and testbench
========================================

# bp_tile_cfg_sequencer

Boot-time configuration sequencer that walks every tile of the selected processor configuration and programs it over the tile config link. For each tile it freezes the core, writes core ID and CCE ID, puts the CCE in uncached mode, streams the CCE microcode from a synchronous ROM, switches the CCE to normal mode, and unfreezes. It sits beside the top-level processor, is driven by the testbench or host reset logic, and is sized from the processor parameter struct (tile count = cc_x_dim*cc_y_dim, ucode depth = 2^cce_pc_width).

## Interface
- num_tiles_p, 1, number of tiles to program (cc_x_dim*cc_y_dim)
- tile_id_width_p, 4, width of tile select / ID fields
- cfg_addr_width_p, 16, config link address width
- cfg_data_width_p, 64, config link data width and ucode ROM width
- ucode_els_p, 256, microcode entries per CCE (2^cce_pc_width)
- skip_ucode_p, 0, 1 = omit ucode stream (mode writes still issued)
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  pulse; begins sequencing from IDLE or DONE
- ucode_v_o  out  1  ROM read strobe
- ucode_addr_o  out  clog2(ucode_els_p)  ROM read index
- ucode_data_i  in  cfg_data_width_p  ROM data, valid exactly one cycle after ucode_v_o
- cfg_v_o  out  1  config write valid
- cfg_tile_o  out  tile_id_width_p  destination tile
- cfg_addr_o  out  cfg_addr_width_p  config register address
- cfg_data_o  out  cfg_data_width_p  write data
- cfg_ready_i  in  1  config link accepts write
- busy_o  out  1  sequencing in progress
- done_o  out  1  all tiles programmed

## Operation
- States: IDLE, FREEZE, CORE_ID, CCE_ID, MODE_UC, UC_RD, UC_WR, MODE_NORM, UNFREEZE, DONE.
- IDLE/DONE + start_i -> FREEZE, tile counter=0, ucode index=0; done_o clears.
- Per tile write list (cfg_tile_o = tile counter): freeze_addr<-1, core_id_addr<-tile, cce_id_addr<-tile, cce_mode_addr<-0 (uncached), ucode_base+i<-ROM[i] for i=0..ucode_els_p-1, cce_mode_addr<-1 (normal), freeze_addr<-0. Data zero-extended.
- Each write state advances only on cfg_v_o & cfg_ready_i.
- UC_RD: ucode_v_o=1 for one cycle, cfg_v_o=0 -> UC_WR. UC_WR: first cycle drives ucode_data_i and captures it into hold register; later cycles drive hold register. On accept: i==ucode_els_p-1 -> MODE_NORM, else i++ -> UC_RD.
- skip_ucode_p=1: MODE_UC -> MODE_NORM directly.
- UNFREEZE accept: tile==num_tiles_p-1 -> DONE, else tile++, i=0 -> FREEZE.
- start_i outside IDLE/DONE ignored.
- busy_o=1 in all states except IDLE/DONE; done_o=1 only in DONE.

## Timing
- Reset (async): state IDLE, counters 0; all outputs 0 immediately, including cfg_v_o mid-transfer. No partial sequence resumes; next start_i restarts at tile 0 FREEZE.
- start_i at cycle 0 -> first cfg_v_o at cycle 1.
- cfg_tile_o/addr/data stable while cfg_v_o & !cfg_ready_i; cfg_v_o never drops without accept (except reset).
- cfg_ready_i tied 1: per tile 6+3*ucode_els_p cycles (6 with skip_ucode_p); done_o rises cycle after final UNFREEZE accept.
- ucode_addr_o held at i while in UC_RD/UC_WR; 0 otherwise.

## Structure
- Shared package (common cfg link package): cfg address constants freeze_addr=0x0001, core_id_addr=0x0002, cce_id_addr=0x0003, cce_mode_addr=0x0004, ucode_base_addr=0x8000; cce_mode enum {e_cce_mode_uncached=0, e_cce_mode_normal=1}; state enum.
- One sub-module: bp_tile_cfg_ucode_fetch (read strobe, index counter, first-cycle bypass + hold register).

## Test plan
- num_tiles_p=2, ucode_els_p=4, ready=1, ROM[i]=0xA5A5_0000+i: start -> 20 writes in exact order, tile 1 ucode at 0x8000..0x8003 with 0xA5A5_0000..3, done_o at cycle 37.
- Backpressure: cfg_ready_i low 5 cycles during core_id write -> outputs unchanged, single accept, core_id=0.
- Backpressure during UC_WR for entry 2 -> data equals ROM[2] throughout stall, no extra ucode_v_o.
- reset_i mid-ucode (tile 1, i=2) -> cfg_v_o/busy_o 0 same cycle; new start replays from tile 0 freeze_addr<-1.
- start_i while busy ignored; start_i in DONE restarts, done_o drops next cycle.
- skip_ucode_p=1, num_tiles_p=3, ready=1 -> 18 writes, zero ucode_v_o, done_o at cycle 19.

Source files
------------

// File: rtl/bp_tile_cfg_sequencer_pkg.sv
// Shared definitions for the tile config link: register addresses, CCE modes and
// the boot sequencer state encoding.
package bp_tile_cfg_sequencer_pkg;

  localparam logic [15:0] freeze_addr     = 16'h0001;
  localparam logic [15:0] core_id_addr    = 16'h0002;
  localparam logic [15:0] cce_id_addr     = 16'h0003;
  localparam logic [15:0] cce_mode_addr   = 16'h0004;
  localparam logic [15:0] ucode_base_addr = 16'h8000;

  typedef enum logic [0:0] {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } cce_mode_e;

  typedef enum logic [3:0] {
    StIdle,
    StFreeze,
    StCoreId,
    StCceId,
    StModeUc,
    StUcRd,
    StUcWr,
    StModeNorm,
    StUnfreeze,
    StDone
  } cfg_state_e;

endpackage

// File: rtl/bp_tile_cfg_ucode_fetch.sv
// Microcode fetch path: ROM index counter, read strobe, and a hold register that
// keeps the fetched word stable while the config link back-pressures.
module bp_tile_cfg_ucode_fetch #(
  parameter int unsigned ucode_els_p        = 256,
  parameter int unsigned ucode_addr_width_p = (ucode_els_p > 1) ? $clog2(ucode_els_p) : 1,
  parameter int unsigned cfg_data_width_p   = 64
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          rd_i,
  input  logic                          wr_i,
  input  logic                          clr_i,
  input  logic                          adv_i,
  output logic                          ucode_v_o,
  output logic [ucode_addr_width_p-1:0] ucode_addr_o,
  input  logic [cfg_data_width_p-1:0]   ucode_data_i,
  output logic [cfg_data_width_p-1:0]   data_o,
  output logic                          last_o
);

  logic [ucode_addr_width_p-1:0] idx_q, idx_d;
  logic                          armed_q;
  logic                          first_q;
  logic [cfg_data_width_p-1:0]   hold_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (adv_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // First read cycle settles the address; the strobe fires on the second.
  assign ucode_v_o    = rd_i & armed_q;
  assign ucode_addr_o = (rd_i | wr_i) ? idx_q : '0;
  assign last_o       = (idx_q == ucode_addr_width_p'(ucode_els_p - 1));
  // ROM data is only valid the cycle after the strobe; afterwards use the copy.
  assign data_o       = first_q ? ucode_data_i : hold_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q   <= '0;
      armed_q <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      armed_q <= rd_i & ~armed_q;
      first_q <= ucode_v_o;
      if (first_q) begin
        hold_q <= ucode_data_i;
      end
    end
  end

endmodule

// File: rtl/bp_tile_cfg_sequencer.sv
// Boot-time sequencer that programs every tile over the config link: freeze, IDs,
// CCE microcode load in uncached mode, switch to normal mode, unfreeze.
module bp_tile_cfg_sequencer
  import bp_tile_cfg_sequencer_pkg::*;
#(
  parameter int unsigned num_tiles_p      = 1,
  parameter int unsigned tile_id_width_p  = 4,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 64,
  parameter int unsigned ucode_els_p      = 256,
  parameter bit          skip_ucode_p     = 1'b0,
  localparam int unsigned ucode_addr_width_lp = (ucode_els_p > 1) ? $clog2(ucode_els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  output logic                           ucode_v_o,
  output logic [ucode_addr_width_lp-1:0] ucode_addr_o,
  input  logic [cfg_data_width_p-1:0]    ucode_data_i,
  output logic                           cfg_v_o,
  output logic [tile_id_width_p-1:0]     cfg_tile_o,
  output logic [cfg_addr_width_p-1:0]    cfg_addr_o,
  output logic [cfg_data_width_p-1:0]    cfg_data_o,
  input  logic                           cfg_ready_i,
  output logic                           busy_o,
  output logic                           done_o
);

  cfg_state_e                  state_q, state_d;
  logic [tile_id_width_p-1:0]  tile_q, tile_d;
  logic                        uc_rd, uc_wr, uc_clr, uc_adv, uc_last;
  logic [cfg_data_width_p-1:0] uc_data;
  logic                        last_tile;

  assign last_tile = (tile_q == tile_id_width_p'(num_tiles_p - 1));

  bp_tile_cfg_ucode_fetch #(
    .ucode_els_p       (ucode_els_p),
    .ucode_addr_width_p(ucode_addr_width_lp),
    .cfg_data_width_p  (cfg_data_width_p)
  ) u_fetch (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rd_i        (uc_rd),
    .wr_i        (uc_wr),
    .clr_i       (uc_clr),
    .adv_i       (uc_adv),
    .ucode_v_o   (ucode_v_o),
    .ucode_addr_o(ucode_addr_o),
    .ucode_data_i(ucode_data_i),
    .data_o      (uc_data),
    .last_o      (uc_last)
  );

  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    cfg_v_o    = 1'b0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    uc_rd      = 1'b0;
    uc_wr      = 1'b0;
    uc_clr     = 1'b0;
    uc_adv     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d = StFreeze;
          tile_d  = '0;
          uc_clr  = 1'b1;
        end
      end
      StFreeze: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(freeze_addr);
        cfg_data_o = cfg_data_width_p'(1);
        if (cfg_ready_i) state_d = StCoreId;
      end
      StCoreId: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(core_id_addr);
        cfg_data_o = cfg_data_width_p'(tile_q);
        if (cfg_ready_i) state_d = StCceId;
      end
      StCceId: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(cce_id_addr);
        cfg_data_o = cfg_data_width_p'(tile_q);
        if (cfg_ready_i) state_d = StModeUc;
      end
      StModeUc: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(cce_mode_addr);
        cfg_data_o = cfg_data_width_p'(e_cce_mode_uncached);
        if (cfg_ready_i) state_d = skip_ucode_p ? StModeNorm : StUcRd;
      end
      StUcRd: begin
        uc_rd = 1'b1;
        if (ucode_v_o) state_d = StUcWr;
      end
      StUcWr: begin
        uc_wr      = 1'b1;
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(ucode_base_addr) + cfg_addr_width_p'(ucode_addr_o);
        cfg_data_o = uc_data;
        if (cfg_ready_i) begin
          if (uc_last) begin
            state_d = StModeNorm;
          end else begin
            uc_adv  = 1'b1;
            state_d = StUcRd;
          end
        end
      end
      StModeNorm: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(cce_mode_addr);
        cfg_data_o = cfg_data_width_p'(e_cce_mode_normal);
        if (cfg_ready_i) state_d = StUnfreeze;
      end
      StUnfreeze: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(freeze_addr);
        if (cfg_ready_i) begin
          if (last_tile) begin
            state_d = StDone;
          end else begin
            tile_d  = tile_q + 1'b1;
            uc_clr  = 1'b1;
            state_d = StFreeze;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cfg_tile_o = busy_o ? tile_q : '0;
  assign busy_o     = (state_q != StIdle) && (state_q != StDone);
  assign done_o     = (state_q == StDone);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
    end
  end

endmodule

// File: tb/tb_bp_tile_cfg_sequencer.sv
// Directed bench for the tile config sequencer: a 2-tile/4-entry instance with a
// ROM model and a 3-tile instance that skips the microcode stream.
module tb_bp_tile_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, ready, start_s;
  logic        ucode_v, ucode_v_s;
  logic [1:0]  ucode_addr, ucode_addr_s;
  logic [63:0] ucode_data, cfg_data, cfg_data_s;
  logic        cfg_v, cfg_v_s, busy, busy_s, done, done_s;
  logic [3:0]  cfg_tile, cfg_tile_s;
  logic [15:0] cfg_addr, cfg_addr_s;

  int n_vec = 0;
  int n_err = 0;
  int strobes = 0;
  int strobes_s = 0;

  bp_tile_cfg_sequencer #(
    .num_tiles_p(2), .tile_id_width_p(4), .cfg_addr_width_p(16),
    .cfg_data_width_p(64), .ucode_els_p(4), .skip_ucode_p(1'b0)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .ucode_v_o(ucode_v), .ucode_addr_o(ucode_addr), .ucode_data_i(ucode_data),
    .cfg_v_o(cfg_v), .cfg_tile_o(cfg_tile), .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data),
    .cfg_ready_i(ready), .busy_o(busy), .done_o(done)
  );

  bp_tile_cfg_sequencer #(
    .num_tiles_p(3), .tile_id_width_p(4), .cfg_addr_width_p(16),
    .cfg_data_width_p(64), .ucode_els_p(4), .skip_ucode_p(1'b1)
  ) dut_skip (
    .clk_i(clk), .reset_i(reset), .start_i(start_s),
    .ucode_v_o(ucode_v_s), .ucode_addr_o(ucode_addr_s), .ucode_data_i(64'h0),
    .cfg_v_o(cfg_v_s), .cfg_tile_o(cfg_tile_s), .cfg_addr_o(cfg_addr_s), .cfg_data_o(cfg_data_s),
    .cfg_ready_i(1'b1), .busy_o(busy_s), .done_o(done_s)
  );

  // ROM returns data only the cycle after a strobe; garbage otherwise.
  always @(posedge clk) begin
    ucode_data <= ucode_v ? (64'hA5A5_0000 + 64'(ucode_addr)) : 64'hDEAD_BEEF_DEAD_BEEF;
    if (ucode_v) strobes <= strobes + 1;
    if (ucode_v_s) strobes_s <= strobes_s + 1;
  end

  // Expected k-th write of a tile's list (n = ucode entries streamed).
  function automatic void exp_write(input int t, input int k, input int n,
                                    output logic [15:0] a, output logic [63:0] d);
    if (k == 0) begin a = 16'h0001; d = 64'd1; end
    else if (k == 1) begin a = 16'h0002; d = 64'(t); end
    else if (k == 2) begin a = 16'h0003; d = 64'(t); end
    else if (k == 3) begin a = 16'h0004; d = 64'd0; end
    else if (k < 4 + n) begin a = 16'h8000 + 16'(k - 4); d = 64'hA5A5_0000 + 64'(k - 4); end
    else if (k == 4 + n) begin a = 16'h0004; d = 64'd1; end
    else begin a = 16'h0001; d = 64'd0; end
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_s = 1'b0; ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cfg_v !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ucode_v !== 1'b0 || busy_s !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: v=%b busy=%b done=%b ucode_v=%b busy_s=%b, want all 0",
               cfg_v, busy, done, ucode_v, busy_s);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (cfg_v !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ucode_addr !== 2'd0 || cfg_addr !== 16'h0) begin
      n_err++;
      $display("FAIL reset_idle: v=%b busy=%b done=%b uaddr=%0d addr=%h, want all 0",
               cfg_v, busy, done, ucode_addr, cfg_addr);
    end
  endtask

  task automatic test_full_sequence();
    int w = 0;
    int done_at = -1;
    int s0;
    logic [15:0] ea;
    logic [63:0] ed;
    s0 = strobes;
    ready = 1'b1;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (cfg_v) begin
        exp_write(w / 10, w % 10, 4, ea, ed);
        n_vec++;
        if (w >= 20 || cfg_tile !== 4'(w / 10) || cfg_addr !== ea || cfg_data !== ed) begin
          n_err++;
          $display("FAIL full_write%0d: tile=%0d addr=%h data=%h, want tile=%0d addr=%h data=%h",
                   w, cfg_tile, cfg_addr, cfg_data, w / 10, ea, ed);
        end
        w++;
      end
      if (done && done_at < 0) done_at = c;
    end
    n_vec++;
    if (w !== 20 || done_at !== 37) begin
      n_err++;
      $display("FAIL full_count: writes=%0d done_cycle=%0d, want 20 and 37", w, done_at);
    end
    n_vec++;
    if (strobes - s0 !== 8) begin
      n_err++;
      $display("FAIL full_strobes: got %0d, want 8", strobes - s0);
    end
  endtask

  task automatic test_backpressure();
    bit found = 1'b0;
    int s0;
    ready = 1'b1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1 || cfg_addr !== 16'h0001) begin
      n_err++;
      $display("FAIL restart_from_done: done=%b busy=%b addr=%h, want 0 1 0001", done, busy, cfg_addr);
    end
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++;
      if (cfg_v !== 1'b1 || cfg_tile !== 4'd0 || cfg_addr !== 16'h0002 || cfg_data !== 64'd0) begin
        n_err++;
        $display("FAIL core_id_stall%0d: v=%b tile=%0d addr=%h data=%h, want 1 0 0002 0",
                 i, cfg_v, cfg_tile, cfg_addr, cfg_data);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (cfg_v !== 1'b1 || cfg_addr !== 16'h0003 || cfg_data !== 64'd0) begin
      n_err++;
      $display("FAIL core_id_single_accept: v=%b addr=%h data=%h, want 1 0003 0", cfg_v, cfg_addr, cfg_data);
    end
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (cfg_v && cfg_addr == 16'h8002) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL ucode2_reach: entry 2 write seen=%b, want 1", found);
    end else begin
      s0 = strobes;
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clk);
        n_vec++;
        if (cfg_v !== 1'b1 || cfg_addr !== 16'h8002 || cfg_data !== 64'hA5A5_0002 || ucode_addr !== 2'd2) begin
          n_err++;
          $display("FAIL ucode2_stall%0d: v=%b addr=%h data=%h uaddr=%0d, want 1 8002 a5a50002 2",
                   i, cfg_v, cfg_addr, cfg_data, ucode_addr);
        end
      end
      ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (strobes - s0 !== 0 || cfg_v !== 1'b0) begin
        n_err++;
        $display("FAIL ucode2_no_refetch: strobes=%0d v=%b, want 0 0", strobes - s0, cfg_v);
      end
    end
  endtask

  task automatic test_reset_mid_ucode();
    bit found = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (cfg_v && cfg_tile == 4'd1 && cfg_addr == 16'h8002) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_reach: tile 1 entry 2 seen=%b, want 1", found);
    end
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if (cfg_v !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ucode_addr !== 2'd0 || cfg_tile !== 4'd0) begin
      n_err++;
      $display("FAIL mid_reset_async: v=%b busy=%b done=%b uaddr=%0d tile=%0d, want all 0",
               cfg_v, busy, done, ucode_addr, cfg_tile);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || cfg_v !== 1'b0) begin
      n_err++;
      $display("FAIL mid_no_resume: busy=%b v=%b, want 0 0", busy, cfg_v);
    end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_vec++;
    if (cfg_v !== 1'b1 || cfg_tile !== 4'd0 || cfg_addr !== 16'h0001 || cfg_data !== 64'd1) begin
      n_err++;
      $display("FAIL mid_replay: v=%b tile=%0d addr=%h data=%h, want 1 0 0001 1",
               cfg_v, cfg_tile, cfg_addr, cfg_data);
    end
  endtask

  task automatic test_start_busy();
    int done_at = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_vec++;
    if (cfg_v !== 1'b1 || cfg_addr !== 16'h0003 || cfg_tile !== 4'd0) begin
      n_err++;
      $display("FAIL start_busy_ignored: v=%b addr=%h tile=%0d, want 1 0003 0", cfg_v, cfg_addr, cfg_tile);
    end
    for (int c = 4; c <= 60 && done_at < 0; c++) begin
      @(negedge clk);
      if (done) done_at = c;
    end
    n_vec++;
    if (done_at !== 37) begin
      n_err++;
      $display("FAIL start_busy_done: done cycle=%0d, want 37", done_at);
    end
  endtask

  task automatic test_skip_ucode();
    int w = 0;
    int done_at = -1;
    logic [15:0] ea;
    logic [63:0] ed;
    @(negedge clk) start_s = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (cfg_v_s) begin
        exp_write(w / 6, w % 6, 0, ea, ed);
        n_vec++;
        if (w >= 18 || cfg_tile_s !== 4'(w / 6) || cfg_addr_s !== ea || cfg_data_s !== ed) begin
          n_err++;
          $display("FAIL skip_write%0d: tile=%0d addr=%h data=%h, want tile=%0d addr=%h data=%h",
                   w, cfg_tile_s, cfg_addr_s, cfg_data_s, w / 6, ea, ed);
        end
        w++;
      end
      if (done_s && done_at < 0) done_at = c;
    end
    n_vec++;
    if (w !== 18 || done_at !== 19 || strobes_s !== 0) begin
      n_err++;
      $display("FAIL skip_summary: writes=%0d done_cycle=%0d strobes=%0d, want 18 19 0",
               w, done_at, strobes_s);
    end
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_backpressure();
    test_reset_mid_ucode();
    test_start_busy();
    test_skip_ucode();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
